// File: rtl/ahb2wb_bridge_p.sv
// AHB-Lite slave to Wishbone classic master bridge, one Wishbone cycle per AHB beat.
// Wishbone errors and ack timeouts are both returned as the two-cycle AHB ERROR response.
module ahb2wb_bridge_p #(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                hclk,
  input  logic                hresetn,
  input  logic                hsel,
  input  logic [AWIDTH-1:0]   haddr,
  input  logic [1:0]          htrans,
  input  logic [2:0]          hsize,
  input  logic [2:0]          hburst,
  input  logic                hwrite,
  input  logic [DWIDTH-1:0]   hwdata,
  output logic                hready,
  output logic [DWIDTH-1:0]   hrdata,
  output logic [1:0]          hresp,
  output logic                cyc_o,
  output logic                stb_o,
  output logic                we_o,
  output logic [AWIDTH-1:0]   adr_o,
  output logic [DWIDTH-1:0]   dat_o,
  output logic [DWIDTH/8-1:0] sel_o,
  input  logic [DWIDTH-1:0]   dat_i,
  input  logic                ack_i,
  input  logic                err_i
);

  localparam int NB     = DWIDTH / 8;
  localparam int LOG_NB = $clog2(NB);
  localparam int CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WDATA = 3'd1;
  localparam logic [2:0] S_WB    = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR1  = 3'd4;
  localparam logic [2:0] S_ERR2  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [AWIDTH-1:0] adr_q, adr_d;
  logic              we_q, we_d;
  logic [NB-1:0]     sel_q, sel_d;
  logic [DWIDTH-1:0] dat_q, dat_d;
  logic [DWIDTH-1:0] hrdata_q, hrdata_d;
  logic [CW-1:0]     tmo_q, tmo_d;

  logic              sample;
  logic              size_ok;
  logic              tmo_hit;
  logic [3:0]        lane_bytes;
  logic [3:0]        lane_lo;
  logic [NB-1:0]     lane_sel;
  logic              unused_ok;

  // Burst type and the SEQ/NONSEQ distinction do not matter: every beat is converted alone.
  assign unused_ok = ^{hburst, htrans[0]};

  assign sample  = ((state_q == S_IDLE) || (state_q == S_DONE)) && hsel && htrans[1];
  assign size_ok = (hsize <= 3'(LOG_NB));
  assign tmo_hit = (TIMEOUT > 0) && (tmo_q == CW'(TIMEOUT - 1));

  // Lane window starts at the low address bits aligned down to the transfer size.
  assign lane_bytes = size_ok ? (4'd1 << hsize) : 4'd0;
  assign lane_lo    = ({1'b0, haddr[2:0]} & 4'(NB - 1)) & ~(lane_bytes - 4'd1);

  always_comb begin
    lane_sel = '0;
    for (int i = 0; i < NB; i++) begin
      lane_sel[i] = (4'(i) >= lane_lo) && (4'(i) < (lane_lo + lane_bytes));
    end
  end

  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    we_d     = we_q;
    sel_d    = sel_q;
    dat_d    = dat_q;
    hrdata_d = hrdata_q;
    tmo_d    = tmo_q;

    if (sample) begin
      adr_d = haddr;
      we_d  = hwrite;
      sel_d = lane_sel;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (!sample) begin
          state_d = S_IDLE;
        end else if (!size_ok) begin
          state_d = S_ERR1;
        end else if (hwrite) begin
          state_d = S_WDATA;
        end else begin
          state_d = S_WB;
          tmo_d   = '0;
        end
      end
      S_WDATA: begin
        dat_d   = hwdata;
        state_d = S_WB;
        tmo_d   = '0;
      end
      S_WB: begin
        if (tmo_q != CW'(TIMEOUT)) tmo_d = tmo_q + 1'b1;
        // Error beats ack; an ack arriving on the last allowed cycle still completes.
        if (err_i) begin
          state_d = S_ERR1;
        end else if (ack_i) begin
          state_d = S_DONE;
          if (!we_q) hrdata_d = dat_i;
        end else if (tmo_hit) begin
          state_d = S_ERR1;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      S_ERR2:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= S_IDLE;
      adr_q    <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      dat_q    <= '0;
      hrdata_q <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      dat_q    <= dat_d;
      hrdata_q <= hrdata_d;
      tmo_q    <= tmo_d;
    end
  end

  // Decoding strobes from state lets the async reset drop them without an edge.
  assign hready = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR2);
  assign hresp  = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? 2'b01 : 2'b00;
  assign cyc_o  = (state_q == S_WB);
  assign stb_o  = (state_q == S_WB);
  assign we_o   = we_q;
  assign adr_o  = adr_q;
  assign dat_o  = dat_q;
  assign sel_o  = sel_q;
  assign hrdata = hrdata_q;

endmodule

// File: tb/tb_ahb2wb_bridge_p.sv
// Scoreboarded bench for ahb2wb_bridge_p: AHB master tasks, a Wishbone slave model with
// programmable ack delay / error / no-ack, and a monitor that pops expected responses.
module tb_ahb2wb_bridge_p;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          hclk;
  logic          hresetn;
  logic          hsel;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic          hwrite;
  logic [DW-1:0] hwdata;
  logic          hready;
  logic [DW-1:0] hrdata;
  logic [1:0]    hresp;
  logic          cyc_o, stb_o, we_o;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_o;
  logic [3:0]    sel_o;
  logic [DW-1:0] dat_i;
  logic          ack_i;
  logic          err_i;

  ahb2wb_bridge_p #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(4)) dut (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hsize(hsize), .hburst(hburst), .hwrite(hwrite), .hwdata(hwdata),
    .hready(hready), .hrdata(hrdata), .hresp(hresp),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .sel_o(sel_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    logic        rd;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } sb_t;

  sb_t sb_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Wishbone slave model
  logic        ack_en, ack_tied, err_en;
  int          ack_dly;
  int          slv_cnt = 0;
  int          stb_cyc = 0;
  int          wb_ends = 0;
  logic [31:0] slv_rdata;

  always @(negedge hclk) begin
    dat_i = slv_rdata;
    if (stb_o) begin
      stb_cyc++;
      ack_i = ack_tied || (ack_en && (slv_cnt == ack_dly));
      err_i = err_en && (slv_cnt == ack_dly);
      if (ack_i || err_i) wb_ends++;
      slv_cnt++;
    end else begin
      slv_cnt = 0;
      ack_i   = ack_tied;
      err_i   = 1'b0;
    end
  end

  // Response monitor: pops one expectation per completed AHB data phase
  logic pend = 1'b0;
  always @(negedge hclk) begin
    sb_t e;
    if (!hresetn) begin
      pend = 1'b0;
    end else begin
      if (pend && hready) begin
        chk_eq("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk_eq("hresp", 64'(hresp), 64'(e.resp));
          if (e.rd && (e.resp == 2'b00)) chk_eq("hrdata", 64'(hrdata), 64'(e.rdata));
        end
      end
      if (hready) pend = hsel && htrans[1];
    end
  end

  task automatic push_exp(input logic rd, input logic [1:0] resp, input logic [31:0] rdata);
    sb_t e;
    e.rd = rd; e.resp = resp; e.rdata = rdata;
    sb_q.push_back(e);
  endtask

  // Single NONSEQ beat; returns wait-state count and hresp of the last wait cycle.
  task automatic ahb_xfer(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                          input logic [31:0] wd, input logic [1:0] eresp,
                          input logic [31:0] erd, input logic [3:0] esel,
                          input logic wbchk, output int ws, output logic [1:0] lresp);
    logic seen;
    push_exp(!wr, eresp, erd);
    hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = wr; hsize = sz; hburst = 3'd0;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;
    ws = 0; seen = 1'b0; lresp = 2'b00;
    for (int i = 0; i < 40 && !hready; i++) begin
      lresp = hresp;
      if (wbchk && stb_o && !seen) begin
        seen = 1'b1;
        chk_eq("adr_o", 64'(adr_o), 64'(a));
        chk_eq("we_o", 64'(we_o), 64'(wr));
        chk_eq("sel_o", 64'(sel_o), 64'(esel));
        if (wr) chk_eq("dat_o", 64'(dat_o), 64'(wd));
      end
      ws++;
      @(posedge hclk); #1;
    end
    chk_eq("xfer_done_in_budget", 64'(hready), 64'd1);
    if (wbchk) chk_eq("wb_cycle_seen", 64'(seen), 64'd1);
    @(posedge hclk); #1;
  endtask

  int          ws;
  logic [1:0]  lr;
  int          ends0;
  logic [4:0]  hr;

  initial begin
    hresetn = 1'b0; hsel = 1'b0; htrans = 2'b00; haddr = '0; hsize = 3'd0;
    hburst = 3'd0; hwrite = 1'b0; hwdata = '0;
    ack_en = 1'b1; ack_tied = 1'b0; err_en = 1'b0; ack_dly = 0; slv_rdata = '0;
    dat_i = '0; ack_i = 1'b0; err_i = 1'b0;
    #3;
    chk_eq("rst_hready", 64'(hready), 64'd1);
    chk_eq("rst_hresp", 64'(hresp), 64'd0);
    chk_eq("rst_cyc", 64'(cyc_o), 64'd0);
    chk_eq("rst_stb", 64'(stb_o), 64'd0);
    chk_eq("rst_sel", 64'(sel_o), 64'd0);
    chk_eq("rst_hrdata", 64'(hrdata), 64'd0);
    repeat (2) @(posedge hclk);
    #1 hresetn = 1'b1;
    @(posedge hclk); #1;

    // Read with ack two cycles after stb_o
    slv_rdata = 32'hDEADBEEF; ack_dly = 2;
    ahb_xfer(32'h10, 1'b0, 3'd2, 32'h0, 2'b00, 32'hDEADBEEF, 4'hF, 1'b1, ws, lr);
    chk_eq("t2_wait_states", 64'(ws), 64'd3);

    // Byte write to the top lane
    ack_dly = 0;
    ahb_xfer(32'h23, 1'b1, 3'd0, 32'hAB000000, 2'b00, 32'h0, 4'b1000, 1'b1, ws, lr);
    chk_eq("t3_wait_states", 64'(ws), 64'd2);
    chk_eq("hrdata_held_after_write", 64'(hrdata), 64'hDEADBEEF);

    // More lane patterns, including an unaligned word access
    slv_rdata = 32'h0BADF00D;
    ahb_xfer(32'h05, 1'b0, 3'd0, 32'h0, 2'b00, 32'h0BADF00D, 4'b0010, 1'b1, ws, lr);
    chk_eq("rd_min_wait", 64'(ws), 64'd1);
    ahb_xfer(32'h12, 1'b1, 3'd1, 32'h5A5A0000, 2'b00, 32'h0, 4'b1100, 1'b1, ws, lr);
    slv_rdata = 32'h600DCAFE;
    ahb_xfer(32'h16, 1'b0, 3'd2, 32'h0, 2'b00, 32'h600DCAFE, 4'b1111, 1'b1, ws, lr);

    // Back-to-back read then write with ack tied high
    slv_rdata = 32'h12345678; ack_tied = 1'b1; ends0 = wb_ends;
    push_exp(1'b1, 2'b00, 32'h12345678);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h40; hwrite = 1'b0; hsize = 3'd2;
    @(posedge hclk); #1; hr[0] = hready;
    push_exp(1'b0, 2'b00, 32'h0);
    haddr = 32'h44; hwrite = 1'b1;
    @(posedge hclk); #1; hr[1] = hready;
    @(posedge hclk); #1; hr[2] = hready;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'hC0FFEE00;
    @(posedge hclk); #1; hr[3] = hready;
    chk_eq("t4_dat_o", 64'(dat_o), 64'hC0FFEE00);
    chk_eq("t4_adr_o", 64'(adr_o), 64'h44);
    chk_eq("t4_we_o", 64'(we_o), 64'd1);
    @(posedge hclk); #1; hr[4] = hready;
    chk_eq("t4_hready_pattern", 64'(hr), 64'b10010);
    @(posedge hclk); #1;
    chk_eq("t4_wb_cycles", 64'(wb_ends - ends0), 64'd2);
    ack_tied = 1'b0;

    // Ack timeout after four strobe cycles
    ack_en = 1'b0; stb_cyc = 0;
    ahb_xfer(32'h30, 1'b0, 3'd2, 32'h0, 2'b01, 32'h0, 4'hF, 1'b1, ws, lr);
    chk_eq("t5_stb_cycles", 64'(stb_cyc), 64'd4);
    chk_eq("t5_wait_states", 64'(ws), 64'd5);
    chk_eq("t5_err1_resp", 64'(lr), 64'd1);
    chk_eq("t5_cyc_low", 64'(cyc_o), 64'd0);
    ack_en = 1'b1;

    // err_i together with ack_i: error wins, read data not updated
    slv_rdata = 32'h11111111; err_en = 1'b1;
    ahb_xfer(32'h34, 1'b0, 3'd2, 32'h0, 2'b01, 32'h0, 4'hF, 1'b1, ws, lr);
    chk_eq("t6_err_wait", 64'(ws), 64'd2);
    chk_eq("t6_hrdata_kept", 64'(hrdata), 64'h12345678);
    err_en = 1'b0;

    // Oversize transfer: error with no Wishbone cycle
    stb_cyc = 0;
    ahb_xfer(32'h00, 1'b0, 3'd3, 32'h0, 2'b01, 32'h0, 4'h0, 1'b0, ws, lr);
    chk_eq("t6_size_wait", 64'(ws), 64'd1);
    chk_eq("t6_size_no_stb", 64'(stb_cyc), 64'd0);
    chk_eq("sb_drained", 64'(sb_q.size()), 64'd0);

    // Asynchronous reset in the middle of a Wishbone read
    ack_en = 1'b0;
    push_exp(1'b1, 2'b00, 32'h0);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h50; hwrite = 1'b0; hsize = 3'd2;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00;
    chk_eq("t1_pre_stb", 64'(stb_o), 64'd1);
    #2 hresetn = 1'b0;
    #1;
    chk_eq("t1_cyc", 64'(cyc_o), 64'd0);
    chk_eq("t1_stb", 64'(stb_o), 64'd0);
    chk_eq("t1_hready", 64'(hready), 64'd1);
    sb_q.delete();
    @(posedge hclk); #1 hresetn = 1'b1;
    @(posedge hclk); #1;
    chk_eq("t1_idle_after", 64'(stb_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
